mux_rr_nx1: RTL and testbench
=============================

# mux_rr_nx1

Parametrised N-to-1 round-robin interleaving multiplexer for the PCIe datapath, with per-channel valid/ready handshakes and a registered output stage. It merges `CHANNELS` lane streams of `WIDTH` bits into one stream and tags each output word with its source channel. Arbitration is either strict time-division (fixed slot rotation) or work-conserving (idle channels skipped), selected at compile time. It is the next generation of the two-input, 8-bit alternating mux.

## Interface
- `WIDTH`, 8: data width per channel, ≥1.
- `CHANNELS`, 2: number of input channels, ≥2. Need not be a power of two.
- `SEL_W`, derived: `max(1, $clog2(CHANNELS))`. Width of the pointer and `out_chan`.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset_L`, in, 1: synchronous, active-low reset.
- `in_data`, in, CHANNELS*WIDTH: flattened inputs. Channel c occupies `[c*WIDTH +: WIDTH]`.
- `in_valid`, in, CHANNELS: per-channel data valid.
- `in_ready`, out, CHANNELS: per-channel accept. Combinational.
- `out_data`, out, WIDTH: registered output word.
- `out_chan`, out, SEL_W: registered source-channel index of `out_data`.
- `out_valid`, out, 1: registered output valid.
- `out_ready`, in, 1: downstream accept.

## Operation
- State: rotation pointer `ptr` (SEL_W bits, range 0..CHANNELS-1) and the output register (`out_data`, `out_chan`, `out_valid`).
- `load_en = reset_L & (!out_valid | out_ready)`.
- Grant channel `g`:
  - TDM mode: `g = ptr`.
  - Skip-idle mode: `g` is the first c with `in_valid[c]=1`, searching ptr, ptr+1, … with wrap.
- Ready: `in_ready[c] = load_en & (c == g)`. At most one bit is set. All bits are 0 while `reset_L=0`.
- Transfer on channel c: `in_valid[c] & in_ready[c]`. On a transfer, the next edge loads `out_data <= in_data[g]`, `out_chan <= g`, `out_valid <= 1`.
- When `load_en=1` and no transfer occurs, the next edge sets `out_valid <= 0`. `out_data` and `out_chan` keep their last values.
- When `load_en=0` (stalled), the output register and `ptr` are held.
- Pointer update:
  - TDM: when `load_en=1`, `ptr <= ptr+1`, or 0 if `ptr==CHANNELS-1`. This applies whether or not the slot channel was valid, so an empty slot is a bubble.
  - Skip-idle: on a transfer, `ptr <= g+1` (mod CHANNELS). With no transfer, `ptr` is held.
- Wrap is explicit compare-to-`CHANNELS-1`, never natural overflow. This is required for non-power-of-two counts.
- Reset values (edge with `reset_L=0`): `ptr=0`, `out_valid=0`, `out_data=0`, `out_chan=0`.
- Reset mid-stream drops the word held in the output register. There is no flush.

## Timing
- Latency is 1 cycle: a transfer at edge k gives `out_valid=1` after edge k.
- Throughput is one word per cycle while `out_ready=1` and the granted channel is valid.
- While `out_valid=1` and `out_ready=0`, `out_data` and `out_chan` are stable and every `in_ready` is 0.
- Simultaneous downstream pop and new load in the same cycle is allowed, with no bubble.
- `in_ready` depends combinationally on `out_ready`, `in_valid` (skip-idle mode only), and state. `in_ready` never depends on `in_data`.
- On the first edge with `reset_L=1` after reset: ptr=0, so channel 0 is granted first.

## Configuration
- Macro: `MUX_RR_SKIP_IDLE_EN`.
- Defined: work-conserving skip-idle arbitration as specified above. No bubbles while any channel is valid, and grants are round-robin fair.
- Undefined: strict TDM. The slot order is fixed at 0..CHANNELS-1 and invalid slots produce `out_valid=0` bubbles. This mode is required where the downstream de-interleaver relies on positional slots.

## Test plan
- Reset: CHANNELS=4, WIDTH=8. Hold `reset_L=0` for 2 cycles with all `in_valid=1` → `in_ready=4'b0000`, `out_valid=0`, `out_data=8'h00`, `out_chan=0`.
- TDM full load: channel i drives `8'hA0+i`, all valid, `out_ready=1` → `out_data` sequence A0,A1,A2,A3,A0…, `out_chan` 0,1,2,3,0, `out_valid` continuously 1.
- TDM bubble: only ch2 valid with `8'h5C` → `out_valid=1` in 1 of every 4 cycles, with `out_chan=2` and `out_data=8'h5C`. `out_valid=0` in the other 3 cycles.
- Skip-idle (macro defined): only ch1 (`8'h11`) and ch3 (`8'h33`) valid → output alternates 11,33,11,33 with `out_valid` continuously 1. Raising ch0 after a ch3 grant makes ch0 the next word.
- Backpressure: drop `out_ready` to 0 for 3 cycles while `out_valid=1` → `out_data` held, all `in_ready=0`, `ptr` unchanged. After release, the next channel in order appears with no word lost or duplicated (scoreboard).
- Non-power-of-two: CHANNELS=3, TDM → `out_chan` sequence 0,1,2,0,1. Assert `reset_L=0` for 1 cycle mid-stream → `out_valid=0`, then the first post-reset word has `out_chan=0`.

Source files
------------

// File: rtl/mux_rr_nx1.sv
// N-to-1 round-robin interleaving mux with a registered output stage and source-channel tag.
// Define MUX_RR_SKIP_IDLE_EN for work-conserving skip-idle arbitration; default is strict TDM slots.
module mux_rr_nx1 #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          dbg_ptr
);

    // Handshake: a word moves on any edge where valid and ready are both high on the same
    // side; in_ready is never gated by in_data, and the output register only reloads when
    // it is empty or being popped in the same cycle.

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_chan;
    logic             r_valid;

    logic             w_load_en;
    logic [SEL_W-1:0] w_grant;
    logic [SEL_W-1:0] w_grant_inc;
    logic             w_xfer;
    logic [WIDTH-1:0] w_lane [CHANNELS];

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        assign w_lane[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    assign w_load_en = reset_L & (~r_valid | out_ready);

`ifdef MUX_RR_SKIP_IDLE_EN
    localparam logic [SEL_W:0] CH_EXT = (SEL_W + 1)'(CHANNELS);

    logic [2*CHANNELS-1:0] w_rot;
    logic [SEL_W-1:0]      w_off;
    logic [SEL_W:0]        w_sum;

    // Rotate the valid vector so bit 0 is the pointer's channel; the lowest set bit is the winner.
    always_comb begin
        w_rot = {in_valid, in_valid} >> r_ptr;
        w_off = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = SEL_W'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= CH_EXT) begin
            w_sum = w_sum - CH_EXT;
        end
        w_grant = w_sum[SEL_W-1:0];
    end
`else
    assign w_grant = r_ptr;
`endif

    assign w_grant_inc = (w_grant == LAST_CH) ? '0 : w_grant + 1'b1;
    assign w_xfer      = w_load_en & in_valid[w_grant];
    assign in_ready    = w_load_en ? (CHANNELS'(1) << w_grant) : '0;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_ptr   <= '0;
            r_data  <= '0;
            r_chan  <= '0;
            r_valid <= 1'b0;
        end else if (w_load_en) begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_data <= w_lane[w_grant];
                r_chan <= w_grant;
            end
`ifdef MUX_RR_SKIP_IDLE_EN
            if (w_xfer) begin
                r_ptr <= w_grant_inc;
            end
`else
            // Slot advances even when empty so positions stay fixed for the de-interleaver.
            r_ptr <= w_grant_inc;
`endif
        end
    end

    assign out_data  = r_data;
    assign out_chan  = r_chan;
    assign out_valid = r_valid;
    assign dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Bench for mux_rr_nx1: a 4-channel and a 3-channel instance run in lockstep against a
// slot/queue reference model; arbitration mode follows MUX_RR_SKIP_IDLE_EN.
module tb_mux_rr_nx1;

  localparam int W = 8;

  logic         clk;
  logic         rst_n [2];
  logic [3:0]   vld   [2];
  logic [W-1:0] din   [2][4];
  logic         ordy  [2];

  logic [3:0]   rdy4;
  logic [2:0]   rdy3;
  logic [W-1:0] od4, od3;
  logic [1:0]   oc4, oc3, dp4, dp3;
  logic         ov4, ov3;

  int n_total = 0;
  int n_pass  = 0;

  // reference model state
  int           m_ptr  [2];
  logic         m_ov   [2];
  logic [W-1:0] m_od   [2];
  int           m_oc   [2];
  bit           m_init [2];
  logic [9:0]   exp_q0 [$];
  logic [9:0]   exp_q1 [$];

  mux_rr_nx1 #(.WIDTH(W), .CHANNELS(4)) dut4 (
    .clk      (clk),
    .reset_L  (rst_n[0]),
    .in_data  ({din[0][3], din[0][2], din[0][1], din[0][0]}),
    .in_valid (vld[0]),
    .in_ready (rdy4),
    .out_data (od4),
    .out_chan (oc4),
    .out_valid(ov4),
    .out_ready(ordy[0]),
    .dbg_ptr  (dp4)
  );

  mux_rr_nx1 #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .clk      (clk),
    .reset_L  (rst_n[1]),
    .in_data  ({din[1][2], din[1][1], din[1][0]}),
    .in_valid (vld[1][2:0]),
    .in_ready (rdy3),
    .out_data (od3),
    .out_chan (oc3),
    .out_valid(ov3),
    .out_ready(ordy[1]),
    .dbg_ptr  (dp3)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s ch%0d-dut: got %0h expected %0h", tag, nch(d), obs, exp);
  endtask

  // which channel the spec rules grant this cycle
  function automatic int grant(input int d);
    int n;
    n = nch(d);
`ifdef MUX_RR_SKIP_IDLE_EN
    for (int k = 0; k < n; k++) begin
      if (vld[d][(m_ptr[d] + k) % n]) return (m_ptr[d] + k) % n;
    end
`endif
    return m_ptr[d];
  endfunction

  task automatic model_cycle(input int d);
    int           n, g;
    logic         load;
    logic [3:0]   rdy_o;
    logic [W-1:0] od_o;
    logic [1:0]   oc_o, dp_o;
    logic         ov_o;
    logic [31:0]  exp_w;
    n = nch(d);
    g = grant(d);
    if (d == 0) begin
      rdy_o = rdy4; od_o = od4; oc_o = oc4; dp_o = dp4; ov_o = ov4;
    end else begin
      rdy_o = {1'b0, rdy3}; od_o = od3; oc_o = oc3; dp_o = dp3; ov_o = ov3;
    end
    load = rst_n[d] && (!m_ov[d] || ordy[d]);
    chk("in_ready", d, {28'd0, rdy_o}, load ? (32'd1 << g) : 32'd0);
    if (m_init[d]) begin
      chk("out_valid", d, {31'd0, ov_o}, {31'd0, m_ov[d]});
      chk("out_data", d, {24'd0, od_o}, {24'd0, m_od[d]});
      chk("out_chan", d, {30'd0, oc_o}, m_oc[d]);
      chk("ptr", d, {30'd0, dp_o}, m_ptr[d]);
      // scoreboard: every popped word must be the oldest accepted one
      if (ov_o && ordy[d]) begin
        exp_w = 32'hdead_beef;
        if (d == 0 && exp_q0.size() > 0) exp_w = {22'd0, exp_q0.pop_front()};
        if (d == 1 && exp_q1.size() > 0) exp_w = {22'd0, exp_q1.pop_front()};
        chk("sb_word", d, {22'd0, oc_o, od_o}, exp_w);
      end
    end
    if (!rst_n[d]) begin
      m_ptr[d] = 0; m_ov[d] = 1'b0; m_od[d] = '0; m_oc[d] = 0; m_init[d] = 1'b1;
      if (d == 0) exp_q0.delete(); else exp_q1.delete();
    end else if (load) begin
      if (vld[d][g]) begin
        m_ov[d] = 1'b1;
        m_od[d] = din[d][g];
        m_oc[d] = g;
        if (d == 0) exp_q0.push_back({2'(g), din[d][g]});
        else        exp_q1.push_back({2'(g), din[d][g]});
`ifdef MUX_RR_SKIP_IDLE_EN
        m_ptr[d] = (g + 1) % n;
`endif
      end else begin
        m_ov[d] = 1'b0;
      end
`ifndef MUX_RR_SKIP_IDLE_EN
      m_ptr[d] = (m_ptr[d] + 1) % n;
`endif
    end
  endtask

  // driver tasks
  task automatic cycle();
    #1;
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] v, input logic r);
    for (int d = 0; d < 2; d++) begin
      vld[d]  = v;
      ordy[d] = r;
    end
  endtask

  task automatic data_ramp(input logic [W-1:0] base);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) din[d][c] = base + W'(c);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; m_ptr[d] = 0; m_ov[d] = 1'b0; m_od[d] = '0; m_oc[d] = 0; m_init[d] = 1'b0;
    end
    drive(4'hF, 1'b1);
    data_ramp(8'hA0);
    @(negedge clk);

    // reset with every channel valid
    repeat (2) cycle();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // full load
    repeat (9) cycle();

    // single channel: ch2 only
    drive(4'b0100, 1'b1);
    din[0][2] = 8'h5C; din[1][2] = 8'h5C;
    repeat (9) cycle();

    // ch1 and ch3, then ch0 joins
    drive(4'b1010, 1'b1);
    for (int d = 0; d < 2; d++) begin
      din[d][1] = 8'h11; din[d][3] = 8'h33; din[d][0] = 8'h0F;
    end
    repeat (6) cycle();
    drive(4'b1011, 1'b1);
    repeat (5) cycle();

    // backpressure while holding a word
    drive(4'hF, 1'b1);
    data_ramp(8'hA0);
    repeat (2) cycle();
    drive(4'hF, 1'b0);
    repeat (3) cycle();
    drive(4'hF, 1'b1);
    repeat (5) cycle();

    // one-cycle reset mid-stream on the 3-channel instance
    rst_n[1] = 1'b0;
    cycle();
    rst_n[1] = 1'b1;
    repeat (5) cycle();

    // randomized traffic
    repeat (400) begin
      for (int d = 0; d < 2; d++) begin
        vld[d]   = 4'($urandom_range(0, 15));
        ordy[d]  = ($urandom_range(0, 3) != 0);
        rst_n[d] = ($urandom_range(0, 63) != 0);
        for (int c = 0; c < 4; c++) din[d][c] = W'($urandom_range(0, 255));
      end
      cycle();
    end

    // drain
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    drive(4'h0, 1'b1);
    repeat (3) cycle();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
